// File: rtl/cgra_power_switch_seq.sv
// ---------------------------------------------------------------------------
// cgra_power_switch_seq
//
// Power-switch sequencer for the external power domains (domain 0 = CGRA).
// Sits between the MCU power-gate request/isolation outputs and the physical
// switch cells. On power-up it turns switch segments on one at a time, to
// limit inrush current, waits a settle time, and then raises the per-domain
// ack. On power-down it turns the segments off in reverse order.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   switch_req_i  [NUM_DOMAINS]         1 = domain requested powered
//   iso_en_i      [NUM_DOMAINS]         1 = domain outputs isolated
//   switch_ack_o  [NUM_DOMAINS]         1 = domain fully powered and settled
//   seg_en_o      [NUM_DOMAINS*NUM_SEG] segment enables, domain d seg k at
//                                       bit d*NUM_SEG+k
//   busy_o                              any domain ramping or settling
//   iso_err_o     [NUM_DOMAINS]         (CGRA_PSW_ISO_CHECK_EN only) sticky:
//                                       isolation released while not ON
//
// Optional feature macro: CGRA_PSW_ISO_CHECK_EN
// ---------------------------------------------------------------------------

// Per-domain sequencer: state machine, segment counter, delay counter.
module cgra_psw_domain #(
    parameter int NUM_SEG       = 4,
    parameter int RAMP_DELAY    = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int CW            = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic [NUM_SEG-1:0] seg_en_o,
    output logic               ack_o,
    output logic               busy_nxt_o   // next-state busy, registered by top
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_SETTLE    = 3'd2,
        S_ON        = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_e;

    localparam logic [CW-1:0] RD_LAST  = CW'(RAMP_DELAY - 1);
    // SETTLE is never entered when SETTLE_CYCLES==0; keep the constant legal.
    localparam logic [CW-1:0] ST_LAST  = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SEG_FULL = CW'(NUM_SEG);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_e          state_q, state_d;
    logic [CW-1:0]   seg_cnt_q, seg_cnt_d;
    logic [CW-1:0]   dly_q, dly_d;
    logic [NUM_SEG-1:0] seg_en_q, seg_en_d;
    logic            ack_q, ack_d;
    logic            busy_d;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_OFF;
            seg_cnt_q <= '0;
            dly_q     <= '0;
            seg_en_q  <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_cnt_q <= seg_cnt_d;
            dly_q     <= dly_d;
            seg_en_q  <= seg_en_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic. A request change always wins over a pending delay
    // step; dropping to zero segments lands directly in OFF.
    always_comb begin
        state_d   = state_q;
        seg_cnt_d = seg_cnt_q;
        dly_d     = dly_q;
        unique case (state_q)
            S_OFF: begin
                if (req_i) begin
                    seg_cnt_d = ONE;
                    dly_d     = '0;
                    state_d   = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (!req_i) begin
                    seg_cnt_d = seg_cnt_q - ONE;
                    dly_d     = '0;
                    state_d   = (seg_cnt_q == ONE) ? S_OFF : S_RAMP_DOWN;
                end else if (dly_q == RD_LAST) begin
                    dly_d = '0;
                    if (seg_cnt_q < SEG_FULL) begin
                        seg_cnt_d = seg_cnt_q + ONE;
                    end else begin
                        state_d = (SETTLE_CYCLES == 0) ? S_ON : S_SETTLE;
                    end
                end else begin
                    dly_d = dly_q + ONE;
                end
            end
            S_SETTLE, S_ON: begin
                if (!req_i) begin
                    seg_cnt_d = seg_cnt_q - ONE;
                    dly_d     = '0;
                    state_d   = (seg_cnt_q == ONE) ? S_OFF : S_RAMP_DOWN;
                end else if (state_q == S_SETTLE) begin
                    if (dly_q == ST_LAST) begin
                        dly_d   = '0;
                        state_d = S_ON;
                    end else begin
                        dly_d = dly_q + ONE;
                    end
                end
            end
            S_RAMP_DOWN: begin
                if (req_i) begin
                    // Resume ramp-up from the current level.
                    seg_cnt_d = seg_cnt_q + ONE;
                    dly_d     = '0;
                    state_d   = S_RAMP_UP;
                end else if (dly_q == RD_LAST) begin
                    seg_cnt_d = seg_cnt_q - ONE;
                    dly_d     = '0;
                    if (seg_cnt_q == ONE) state_d = S_OFF;
                end else begin
                    dly_d = dly_q + ONE;
                end
            end
            default: begin
                state_d   = S_OFF;
                seg_cnt_d = '0;
                dly_d     = '0;
            end
        endcase
    end

    // Output decode from next state so the outputs come straight from flops.
    always_comb begin
        seg_en_d = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            seg_en_d[k] = (CW'(k) < seg_cnt_d);
        end
        ack_d  = (state_d == S_ON);
        busy_d = (state_d == S_RAMP_UP) || (state_d == S_SETTLE) ||
                 (state_d == S_RAMP_DOWN);
    end

    assign seg_en_o   = seg_en_q;
    assign ack_o      = ack_q;
    assign busy_nxt_o = busy_d;

endmodule

module cgra_power_switch_seq #(
    parameter int NUM_DOMAINS   = 1,
    parameter int NUM_SEG       = 4,
    parameter int RAMP_DELAY    = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_DOMAINS-1:0]         switch_req_i,
    input  logic [NUM_DOMAINS-1:0]         iso_en_i,
    output logic [NUM_DOMAINS-1:0]         switch_ack_o,
    output logic [NUM_DOMAINS*NUM_SEG-1:0] seg_en_o,
`ifdef CGRA_PSW_ISO_CHECK_EN
    output logic [NUM_DOMAINS-1:0]         iso_err_o,
`endif
    output logic                           busy_o
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_MAX = max3(RAMP_DELAY, SETTLE_CYCLES, NUM_SEG + 1);
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [NUM_DOMAINS-1:0] busy_nxt;
    logic                   busy_q;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        cgra_psw_domain #(
            .NUM_SEG      (NUM_SEG),
            .RAMP_DELAY   (RAMP_DELAY),
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .CW           (CW)
        ) u_dom (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (switch_req_i[d]),
            .seg_en_o  (seg_en_o[d*NUM_SEG +: NUM_SEG]),
            .ack_o     (switch_ack_o[d]),
            .busy_nxt_o(busy_nxt[d])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= 1'b0;
        else       busy_q <= |busy_nxt;
    end
    assign busy_o = busy_q;

`ifdef CGRA_PSW_ISO_CHECK_EN
    // ack is high exactly when a domain is in ON, so it doubles as the
    // "fully powered" qualifier for the isolation check.
    logic [NUM_DOMAINS-1:0] iso_err_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) iso_err_q <= '0;
        else       iso_err_q <= iso_err_q | (~iso_en_i & ~switch_ack_o);
    end
    assign iso_err_o = iso_err_q;
`else
    // Isolation is not needed for sequencing in this build.
    logic unused_iso;
    assign unused_iso = ^iso_en_i;
`endif

endmodule
